// File: rtl/executs_32.sv
// ============================================================================
// Module   : executs_32
// Brief    : MIPS-32 execute stage: ALU, shifter, set-less-than, LUI and
//            branch/jr target adder, all outputs registered (1-cycle latency).
// Revision : 1.0
// ============================================================================
`default_nettype none

module executs_32 (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Read_data_1,
    input  logic [31:0] Read_data_2,
    input  logic [31:0] Sign_extend,
    input  logic [5:0]  Function_opcode,
    input  logic [5:0]  Exe_opcode,
    input  logic [1:0]  ALUOp,
    input  logic [4:0]  Shamt,
    input  logic        Sftmd,
    input  logic        ALUSrc,
    input  logic        I_format,
    input  logic        Jr,
    input  logic [31:0] PC_plus_4,
    output logic        Zero,
    output logic [31:0] ALU_Result,
    output logic [31:0] Addr_Result
);

    localparam logic [2:0] c_alu_and  = 3'b000;
    localparam logic [2:0] c_alu_or   = 3'b001;
    localparam logic [2:0] c_alu_add  = 3'b010;
    localparam logic [2:0] c_alu_addu = 3'b011;
    localparam logic [2:0] c_alu_xor  = 3'b100;
    localparam logic [2:0] c_alu_nor  = 3'b101;
    localparam logic [2:0] c_alu_sub  = 3'b110;
    localparam logic [2:0] c_alu_subu = 3'b111;

    localparam logic [2:0] c_sft_sll  = 3'b000;
    localparam logic [2:0] c_sft_srl  = 3'b010;
    localparam logic [2:0] c_sft_sllv = 3'b100;
    localparam logic [2:0] c_sft_srlv = 3'b110;
    localparam logic [2:0] c_sft_sra  = 3'b011;
    localparam logic [2:0] c_sft_srav = 3'b111;

    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [5:0]  w_exe_code;
    logic [2:0]  w_alu_ctl;
    logic [31:0] w_core;
    logic [31:0] w_shift;
    logic        w_slt_sel;
    logic        w_slt_signed;
    logic        w_lt;

    logic        zero_d,   zero_q;
    logic [31:0] result_d, result_q;
    logic [31:0] addr_d,   addr_q;

    assign w_a        = Read_data_1;
    assign w_b        = ALUSrc ? Sign_extend : Read_data_2;
    assign w_exe_code = I_format ? {3'b000, Exe_opcode[2:0]} : Function_opcode;

    assign w_alu_ctl[0] = (w_exe_code[0] | w_exe_code[3]) & ALUOp[1];
    assign w_alu_ctl[1] = ~w_exe_code[2] | ~ALUOp[1];
    assign w_alu_ctl[2] = (w_exe_code[1] & ALUOp[1]) | ALUOp[0];

    always_comb begin
        w_core = 32'h0;
        case (w_alu_ctl)
            c_alu_and:  w_core = w_a & w_b;
            c_alu_or:   w_core = w_a | w_b;
            c_alu_add:  w_core = w_a + w_b;
            c_alu_addu: w_core = w_a + w_b;
            c_alu_xor:  w_core = w_a ^ w_b;
            c_alu_nor:  w_core = ~(w_a | w_b);
            c_alu_sub:  w_core = w_a - w_b;
            c_alu_subu: w_core = w_a - w_b;
            default:    w_core = 32'h0;
        endcase
    end

    // Variable shifts take their amount from rs[4:0]; unused funct codes pass B.
    always_comb begin
        w_shift = w_b;
        case (Function_opcode[2:0])
            c_sft_sll:  w_shift = w_b << Shamt;
            c_sft_srl:  w_shift = w_b >> Shamt;
            c_sft_sllv: w_shift = w_b << w_a[4:0];
            c_sft_srlv: w_shift = w_b >> w_a[4:0];
            c_sft_sra:  w_shift = $unsigned($signed(w_b) >>> Shamt);
            c_sft_srav: w_shift = $unsigned($signed(w_b) >>> w_a[4:0]);
            default:    w_shift = w_b;
        endcase
    end

    always_comb begin
        w_slt_sel    = 1'b0;
        w_slt_signed = 1'b0;
        if (I_format) begin
            w_slt_sel    = (Exe_opcode[5:1] == 5'b00101);
            w_slt_signed = ~Exe_opcode[0];
        end else if (ALUOp[1]) begin
            w_slt_sel    = (Function_opcode[5:1] == 5'b10101);
            w_slt_signed = ~Function_opcode[0];
        end
    end

    assign w_lt = w_slt_signed ? ($signed(w_a) < $signed(w_b)) : (w_a < w_b);

    always_comb begin
        result_d = w_core;
        if (w_slt_sel) begin
            result_d = {31'b0, w_lt};
        end else if (I_format && (w_alu_ctl == c_alu_nor)) begin
            result_d = {w_b[15:0], 16'h0000};
        end else if (Sftmd) begin
            result_d = w_shift;
        end
    end

    assign zero_d = (w_core == 32'h0);
    assign addr_d = Jr ? Read_data_1 : (PC_plus_4 + {Sign_extend[29:0], 2'b00});

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            zero_q   <= 1'b0;
            result_q <= 32'h0;
            addr_q   <= 32'h0;
        end else begin
            zero_q   <= zero_d;
            result_q <= result_d;
            addr_q   <= addr_d;
        end
    end

    assign Zero        = zero_q;
    assign ALU_Result  = result_q;
    assign Addr_Result = addr_q;

endmodule

`default_nettype wire

// File: tb/tb_executs_32.sv
// ============================================================================
// Module   : tb_executs_32
// Brief    : Directed self-checking bench for executs_32.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_executs_32;

    logic        clock;
    logic        reset;
    logic [31:0] Read_data_1;
    logic [31:0] Read_data_2;
    logic [31:0] Sign_extend;
    logic [5:0]  Function_opcode;
    logic [5:0]  Exe_opcode;
    logic [1:0]  ALUOp;
    logic [4:0]  Shamt;
    logic        Sftmd;
    logic        ALUSrc;
    logic        I_format;
    logic        Jr;
    logic [31:0] PC_plus_4;
    logic        Zero;
    logic [31:0] ALU_Result;
    logic [31:0] Addr_Result;

    int n_compared;
    int n_mismatched;

    executs_32 u_dut (
        .clock           (clock),
        .reset           (reset),
        .Read_data_1     (Read_data_1),
        .Read_data_2     (Read_data_2),
        .Sign_extend     (Sign_extend),
        .Function_opcode (Function_opcode),
        .Exe_opcode      (Exe_opcode),
        .ALUOp           (ALUOp),
        .Shamt           (Shamt),
        .Sftmd           (Sftmd),
        .ALUSrc          (ALUSrc),
        .I_format        (I_format),
        .Jr              (Jr),
        .PC_plus_4       (PC_plus_4),
        .Zero            (Zero),
        .ALU_Result      (ALU_Result),
        .Addr_Result     (Addr_Result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_compared++;
        if (obs !== exp_v) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_inputs();
        Read_data_1     = 32'h0;
        Read_data_2     = 32'h0;
        Sign_extend     = 32'h0;
        Function_opcode = 6'h0;
        Exe_opcode      = 6'h0;
        ALUOp           = 2'b10;
        Shamt           = 5'd0;
        Sftmd           = 1'b0;
        ALUSrc          = 1'b0;
        I_format        = 1'b0;
        Jr              = 1'b0;
        PC_plus_4       = 32'h0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rtype(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b);
        clear_inputs();
        Function_opcode = funct;
        Read_data_1     = a;
        Read_data_2     = b;
    endtask

    task automatic itype(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] imm);
        clear_inputs();
        Exe_opcode  = opc;
        I_format    = 1'b1;
        ALUSrc      = 1'b1;
        Read_data_1 = a;
        Sign_extend = imm;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        clear_inputs();
        reset = 1'b1;
        step();
        check_val("reset_alu",  ALU_Result,  32'h0);
        check_val("reset_zero", {31'b0, Zero}, 32'h0);
        check_val("reset_addr", Addr_Result, 32'h0);
        #2 reset = 1'b0;

        itype(6'b001010, 32'h11, 32'h1);
        PC_plus_4 = 32'h22;
        step();
        check_val("slti_alu",  ALU_Result,  32'h0);
        check_val("slti_zero", {31'b0, Zero}, 32'h0);
        check_val("slti_addr", Addr_Result, 32'h26);

        rtype(6'b100000, 32'd5, 32'd6);
        PC_plus_4 = 32'h100; Sign_extend = 32'h10;
        step();
        check_val("add_alu",  ALU_Result,  32'hB);
        check_val("add_addr", Addr_Result, 32'h140);

        rtype(6'b100010, 32'd7, 32'd7);
        step();
        check_val("sub_zero", {31'b0, Zero}, 32'h1);
        check_val("sub_alu",  ALU_Result,  32'h0);

        rtype(6'b101011, 32'hFFFF_FFFF, 32'h1);
        step();
        check_val("sltu_neg1", ALU_Result, 32'h0);
        rtype(6'b101010, 32'hFFFF_FFFF, 32'h1);
        step();
        check_val("slt_neg1", ALU_Result, 32'h1);
        rtype(6'b101010, 32'h8000_0000, 32'h0);
        step();
        check_val("slt_min", ALU_Result, 32'h1);
        rtype(6'b101011, 32'h8000_0000, 32'h0);
        step();
        check_val("sltu_min", ALU_Result, 32'h0);
        itype(6'b001011, 32'h8000_0000, 32'h0);
        step();
        check_val("sltiu_min", ALU_Result, 32'h0);

        rtype(6'b000011, 32'h0, 32'h8000_0000);
        Sftmd = 1'b1; Shamt = 5'd4;
        step();
        check_val("sra", ALU_Result, 32'hF800_0000);
        rtype(6'b000110, 32'd8, 32'h0000_FF00);
        Sftmd = 1'b1;
        step();
        check_val("srlv", ALU_Result, 32'h0000_00FF);
        rtype(6'b000100, 32'h24, 32'h1);
        Sftmd = 1'b1;
        step();
        check_val("sllv", ALU_Result, 32'h10);
        rtype(6'b000111, 32'h24, 32'h8000_0010);
        Sftmd = 1'b1;
        step();
        check_val("srav", ALU_Result, 32'hF800_0001);
        rtype(6'b000000, 32'h0, 32'h0000_0003);
        Sftmd = 1'b1; Shamt = 5'd31;
        step();
        check_val("sll31", ALU_Result, 32'h8000_0000);

        itype(6'b001111, 32'h0, 32'h1234);
        step();
        check_val("lui", ALU_Result, 32'h1234_0000);

        itype(6'b001100, 32'hF0F0, 32'h0FF0);
        step();
        check_val("andi", ALU_Result, 32'h00F0);
        itype(6'b001101, 32'hF0F0, 32'h0FF0);
        step();
        check_val("ori", ALU_Result, 32'hFFF0);
        itype(6'b001110, 32'hF0F0, 32'h0FF0);
        step();
        check_val("xori", ALU_Result, 32'hFF00);
        rtype(6'b100111, 32'h0, 32'h0);
        step();
        check_val("nor_alu",  ALU_Result,  32'hFFFF_FFFF);
        check_val("nor_zero", {31'b0, Zero}, 32'h0);

        rtype(6'b000000, 32'h55, 32'h55);
        ALUOp = 2'b01; Sign_extend = 32'hFFFF_FFFF; PC_plus_4 = 32'h1000;
        step();
        check_val("beq_zero", {31'b0, Zero}, 32'h1);
        check_val("beq_addr", Addr_Result, 32'h0000_0FFC);
        Read_data_2 = 32'h56;
        step();
        check_val("bne_zero", {31'b0, Zero}, 32'h0);

        rtype(6'b001000, 32'h400, 32'h0);
        Jr = 1'b1; PC_plus_4 = 32'h2000; Sign_extend = 32'h7;
        step();
        check_val("jr_addr", Addr_Result, 32'h400);

        // Reset asserted between edges must clear outputs without a clock.
        rtype(6'b100000, 32'h10, 32'h20);
        PC_plus_4 = 32'h80;
        step();
        check_val("pre_rst_alu", ALU_Result, 32'h30);
        #2 reset = 1'b1;
        #1;
        check_val("async_rst_alu",  ALU_Result,  32'h0);
        check_val("async_rst_addr", Addr_Result, 32'h0);
        step();
        check_val("held_rst_alu", ALU_Result, 32'h0);
        #2 reset = 1'b0;
        #1;
        check_val("post_rel_alu", ALU_Result, 32'h0);
        step();
        check_val("resume_alu",  ALU_Result,  32'h30);
        check_val("resume_addr", Addr_Result, 32'h80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

`default_nettype wire
